// File: rtl/count_step_monitor.sv
// -----------------------------------------------------------------------------
// count_step_monitor
//
// Purpose:
//   This block watches the output of a free-running CNT_W-bit up-counter on
//   every enabled clock. It classifies each transition as one of: hold, +1
//   step, wrap (MAX->0), restart (non-MAX->0) or illegal jump. It reports the
//   result through registered pulses, a saturating wrap (epoch) counter and a
//   sticky step-error flag.
//
// Configuration macro:
//   COUNT_MON_STRICT_EN - when defined, a restart (non-MAX -> 0) counts as an
//                         illegal jump, and restart_pulse is never asserted.
//
// Ports:
//   clk           in   rising-edge clock shared with the counter
//   rst           in   synchronous reset, active-low
//   en            in   sample enable; 0 freezes all state
//   count_in      in   [CNT_W]  counter value being monitored
//   match_val     in   [CNT_W]  compare value for match_pulse
//   clr_err       in   clears the error condition and re-arms (ERROR only)
//   wrap_pulse    out  one-cycle pulse after a MAX->0 sample
//   match_pulse   out  one-cycle pulse when count_in newly equals match_val
//   restart_pulse out  one-cycle pulse after a non-MAX->0 sample
//   step_err      out  sticky illegal-transition flag
//   wrap_cnt      out  [WRAP_W] wraps since reset/restart, saturating
//   last_count    out  [CNT_W]  most recently sampled count_in
// -----------------------------------------------------------------------------
module count_step_monitor #(
  parameter int CNT_W  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [CNT_W-1:0]  match_val,
  input  logic              clr_err,
  output logic              wrap_pulse,
  output logic              match_pulse,
  output logic              restart_pulse,
  output logic              step_err,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0]  last_count
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRP_MAX  = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRP_ZERO = {WRAP_W{1'b0}};
  localparam logic [WRAP_W-1:0] WRP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  last_count_r, last_count_s;
  logic [WRAP_W-1:0] wrap_cnt_r, wrap_cnt_s;
  logic              step_err_r, step_err_s;
  logic              wrap_pulse_r, wrap_pulse_s;
  logic              match_pulse_r, match_pulse_s;
  logic              restart_pulse_r, restart_pulse_s;
  logic [CNT_W-1:0]  step_val_s;
  logic              is_match_s;
  logic [WRAP_W-1:0] wrap_inc_s;

  // Helper values: the expected +1 successor, the match compare, and the saturating epoch increment.
  always_comb begin
    step_val_s = last_count_r + CNT_ONE;
    is_match_s = (count_in == match_val);
    if (wrap_cnt_r == WRP_MAX) begin
      wrap_inc_s = WRP_MAX;
    end else begin
      wrap_inc_s = wrap_cnt_r + WRP_ONE;
    end
  end

  // Next-state and next-output decode; everything holds and pulses stay low unless en is high.
  always_comb begin
    state_s         = state_r;
    last_count_s    = last_count_r;
    wrap_cnt_s      = wrap_cnt_r;
    step_err_s      = step_err_r;
    wrap_pulse_s    = 1'b0;
    match_pulse_s   = 1'b0;
    restart_pulse_s = 1'b0;
    if (en) begin
      // Every enabled state records the sample (IDLE seeds, TRACK/ERROR follow).
      last_count_s = count_in;
      case (state_r)
        IDLE: begin
          // First sample only seeds the history; it cannot be classified.
          state_s = TRACK;
        end
        TRACK: begin
          if (count_in == last_count_r) begin
            state_s = TRACK;
          end else if ((last_count_r == CNT_MAX) && (count_in == CNT_ZERO)) begin
            wrap_pulse_s  = 1'b1;
            wrap_cnt_s    = wrap_inc_s;
            match_pulse_s = is_match_s;
          end else if (count_in == step_val_s) begin
            // step_val_s wraps to zero only when prev is MAX, which the wrap branch already took.
            match_pulse_s = is_match_s;
          end else if (count_in == CNT_ZERO) begin
`ifdef COUNT_MON_STRICT_EN
            step_err_s = 1'b1;
            state_s    = ERROR;
`else
            restart_pulse_s = 1'b1;
            wrap_cnt_s      = WRP_ZERO;
            match_pulse_s   = is_match_s;
`endif
          end else begin
            step_err_s = 1'b1;
            state_s    = ERROR;
          end
        end
        ERROR: begin
          if (clr_err) begin
            step_err_s = 1'b0;
            state_s    = IDLE;
          end else begin
            state_s = ERROR;
          end
        end
        default: begin
          // An unreachable encoding: re-seed from IDLE and keep any error visible.
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r         <= IDLE;
      last_count_r    <= CNT_ZERO;
      wrap_cnt_r      <= WRP_ZERO;
      step_err_r      <= 1'b0;
      wrap_pulse_r    <= 1'b0;
      match_pulse_r   <= 1'b0;
      restart_pulse_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      last_count_r    <= last_count_s;
      wrap_cnt_r      <= wrap_cnt_s;
      step_err_r      <= step_err_s;
      wrap_pulse_r    <= wrap_pulse_s;
      match_pulse_r   <= match_pulse_s;
      restart_pulse_r <= restart_pulse_s;
    end
  end

  assign wrap_pulse    = wrap_pulse_r;
  assign match_pulse   = match_pulse_r;
  assign restart_pulse = restart_pulse_r;
  assign step_err      = step_err_r;
  assign wrap_cnt      = wrap_cnt_r;
  assign last_count    = last_count_r;

endmodule

// File: tb/tb_count_step_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_step_monitor
//
// A scoreboarded bench for count_step_monitor. At every posedge, a reference
// model built from the transition rules pushes the expected output vector. On
// the following negedge, a monitor pops that vector and compares it with the
// DUT. Directed sequences come first; randomized counter traffic follows.
// -----------------------------------------------------------------------------
module tb_count_step_monitor;

  localparam int CW   = 4;
  localparam int TW   = 2;
  localparam int OW   = 4 + TW + CW;
  localparam int MAXV = (1 << CW) - 1;
  localparam int WMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] count_in = '0;
  logic [CW-1:0] match_val = '0;
  logic          clr_err = 1'b0;
  logic          wrap_pulse, match_pulse, restart_pulse, step_err;
  logic [TW-1:0] wrap_cnt;
  logic [CW-1:0] last_count;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] sb[$];

  count_step_monitor #(.CNT_W(CW), .WRAP_W(TW)) dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .match_val(match_val),
    .clr_err(clr_err), .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
    .restart_pulse(restart_pulse), .step_err(step_err), .wrap_cnt(wrap_cnt),
    .last_count(last_count)
  );

  always #5 clk = ~clk;

  // Transition kinds: 0 hold, 1 wrap, 2 step, 3 restart, 4 illegal.
  function automatic int classify(input int p, input int c);
    if (c == p) return 0;
    if (p == MAXV && c == 0) return 1;
    if (c == p + 1) return 2;
    if (c == 0) return 3;
    return 4;
  endfunction

  // Reference model: phase 0 = awaiting seed, 1 = tracking, 2 = errored.
  initial begin
    int phase, prev, wraps, kind;
    bit err, pw, pm, pr;
    phase = 0; prev = 0; wraps = 0; err = 0;
    forever begin
      @(posedge clk);
      pw = 0; pm = 0; pr = 0;
      if (!rst) begin
        phase = 0; prev = 0; wraps = 0; err = 0;
      end else if (en) begin
        if (phase == 0) begin
          phase = 1;
        end else if (phase == 1) begin
          kind = classify(prev, int'(count_in));
`ifdef COUNT_MON_STRICT_EN
          if (kind == 3) kind = 4;
`endif
          if (kind == 1) begin
            pw = 1;
            wraps = (wraps < WMAX) ? wraps + 1 : wraps;
          end
          if (kind == 3) begin
            pr = 1;
            wraps = 0;
          end
          if (kind >= 1 && kind <= 3 && count_in == match_val) pm = 1;
          if (kind == 4) begin
            err = 1;
            phase = 2;
          end
        end else if (clr_err) begin
          err = 0;
          phase = 0;
        end
        prev = int'(count_in);
      end
      sb.push_back({pw, pm, pr, err, TW'(wraps), CW'(prev)});
    end
  end

  // Monitor: compares the DUT outputs against each queued expectation.
  initial begin
    logic [OW-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        act_v = {wrap_pulse, match_pulse, restart_pulse, step_err, wrap_cnt, last_count};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL outputs t=%0t got {wp,mp,rp,err,wcnt,last}=%b,%b,%b,%b,%0d,%0d required=%b,%b,%b,%b,%0d,%0d",
                   $time, act_v[OW-1], act_v[OW-2], act_v[OW-3], act_v[OW-4], act_v[TW+CW-1:CW], act_v[CW-1:0],
                   exp_v[OW-1], exp_v[OW-2], exp_v[OW-3], exp_v[OW-4], exp_v[TW+CW-1:CW], exp_v[CW-1:0]);
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit e, input int c, input int mv, input bit clr);
    rst = r; en = e; count_in = CW'(c); match_val = CW'(mv); clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
  endtask

  initial begin
    int cur, mv, sel;
    bit e, clr, r;
    #1;
    // Reset, then clean steps.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, i, 15, 0);
    // Two wraps with match_val = 5; continuing on until wrap_cnt saturates.
    do_reset();
    for (int w = 0; w < 6; w++)
      for (int i = 0; i < 16; i++) cyc(1, 1, i, 5, 0);
    cyc(1, 1, 0, 5, 0);
    cyc(1, 1, 0, 5, 0);
    // Illegal jump, then clear and re-seed.
    do_reset();
    cyc(1, 1, 3, 9, 0);
    cyc(1, 1, 7, 9, 0);
    cyc(1, 1, 8, 9, 0);
    cyc(1, 1, 9, 9, 0);
    cyc(1, 1, 9, 9, 1);
    cyc(1, 1, 9, 9, 0);
    cyc(1, 1, 10, 10, 0);
    // Restart after some wraps.
    for (int i = 11; i < 16; i++) cyc(1, 1, i, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 4, 0, 0);
    do_reset();
    cyc(1, 1, 4, 0, 0);
    cyc(1, 1, 5, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    // Enable freeze across a jump, clr_err ignored while frozen.
    cyc(1, 1, 6, 11, 0);
    cyc(1, 0, 11, 11, 1);
    cyc(1, 0, 11, 11, 0);
    cyc(1, 1, 7, 11, 0);
    cyc(1, 1, 12, 11, 0);
    cyc(1, 0, 13, 11, 1);
    cyc(0, 1, 13, 11, 1);
    cyc(1, 1, 2, 3, 0);
    cyc(1, 1, 3, 3, 0);
    // Randomized counter traffic.
    cur = 0; mv = 0;
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      r = ($urandom_range(0, 99) >= 2);
      e = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) mv = $urandom_range(0, MAXV);
      if (sel < 72) cur = (cur + 1) % (MAXV + 1);
      else if (sel < 85) cur = cur;
      else if (sel < 92) cur = 0;
      else cur = $urandom_range(0, MAXV);
      cyc(r, e, cur, mv, clr);
    end
    cyc(1, 0, cur, mv, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_step_monitor.md
Name: count_step_monitor

Overview:
- Downstream consumer of the 4-bit free-running up-counter output.
- Samples the counter value every enabled clock and classifies each transition: hold, +1 step, wrap, restart or illegal jump.
- Produces registered wrap and match pulses, an epoch (wrap) count, and a sticky step-error flag.
- Sits between the counter and system-level timing/status logic. It gives downstream logic an integrity-checked view of the counter.

Parameters:
- CNT_W, 4, width of the monitored counter value.
- WRAP_W, 8, width of the wrap/epoch counter.

Ports:
- clk  input  1  rising-edge clock shared with the counter.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on the clk rising edge).
- en  input  1  sample enable; 0 freezes all state.
- count_in  input  CNT_W  counter value being monitored.
- match_val  input  CNT_W  compare value for match_pulse.
- clr_err  input  1  clears the error condition and re-arms the monitor.
- wrap_pulse  output  1  one-cycle pulse on a max->0 transition.
- match_pulse  output  1  one-cycle pulse when count_in newly equals match_val.
- restart_pulse  output  1  one-cycle pulse on a non-max->0 transition (upstream reset seen).
- step_err  output  1  sticky illegal-transition flag.
- wrap_cnt  output  WRAP_W  number of wraps since reset or restart; saturates at max.
- last_count  output  CNT_W  most recently sampled count_in.

Behaviour:
- Reset
  - rst==0 at a posedge has priority over everything.
  - Reset sets state to IDLE and drives every output to 0: all pulses, step_err, wrap_cnt and last_count.
- Timing
  - All outputs are registered. A response appears one clock after the posedge that samples the causing count_in.
  - Pulses last exactly one cycle.
- en==0
  - No state change, no pulses.
  - last_count, wrap_cnt and step_err hold.
  - clr_err is ignored while en==0.
- Notation: MAX = 2^CNT_W-1. prev = last_count.
- FSM states: IDLE, TRACK, ERROR.
- IDLE
  - On en==1: last_count<=count_in, go to TRACK.
  - No pulses are generated from the first sample. This includes match.
- TRACK, with en==1, checked in priority order:
  1. count_in==prev: hold. No pulse.
  2. prev==MAX and count_in==0: wrap. wrap_pulse=1 and wrap_cnt+1, saturating at 2^WRAP_W-1.
  3. count_in==prev+1 with prev!=MAX: normal step.
  4. count_in==0 with prev!=MAX: restart. restart_pulse=1, wrap_cnt<=0.
  5. Anything else: illegal jump. step_err<=1, go to ERROR, no other pulse.
  - In all TRACK cases: last_count<=count_in.
  - match_pulse=1 when count_in==match_val and count_in!=prev, in cases 2-4 only. It can coincide with wrap_pulse or restart_pulse.
  - clr_err in TRACK has no effect.
- ERROR
  - step_err stays 1 and all pulses are suppressed.
  - last_count keeps updating; wrap_cnt holds.
  - clr_err==1 with en==1: step_err<=0, go to IDLE. The next enabled sample re-seeds last_count.
- Reset mid-operation: an active-low rst on any cycle returns the block to IDLE with zeroed outputs on the next edge, regardless of state or clr_err.
- match_val is sampled combinationally each enabled cycle. Changing it mid-run takes effect on the next sample.

Optional Feature:
- Macro: COUNT_MON_STRICT_EN.
- Defined: case 4 (restart) is treated as an illegal jump. This sets step_err, enters ERROR, and never generates restart_pulse (it stays tied to 0).
- Not defined: restart is tolerated as described above.

Test Plan:
- Reset then step: hold rst=0 for 2 clocks. Release with en=1 and count_in 0,1,2,3 on successive edges -> all outputs 0 during reset; no pulses; last_count follows with 1-cycle lag; step_err=0.
- Wrap and epoch count: drive the sequence 0..15,0..15,0 -> wrap_pulse high for exactly one cycle after each 15->0 sample (two pulses); wrap_cnt=2; with match_val=5, exactly two match_pulses.
- Wrap saturation: WRAP_W=2, drive 5 full wraps -> wrap_cnt counts 1,2,3 then holds at 3; wrap_pulse still fires 5 times.
- Illegal jump and clear: drive 3 then 7 -> step_err=1 one cycle later, state ERROR, no pulses. Drive 8,9 -> no pulses. Assert clr_err=1 -> step_err=0. The next sample 9 re-seeds with no pulse; then 10 steps cleanly.
- Restart: sequence 4,5,0 -> restart_pulse=1 once; wrap_cnt=0; step_err=0. With COUNT_MON_STRICT_EN defined, the same sequence gives step_err=1 and restart_pulse=0.
- Enable freeze and mid-run reset: en=0 while count_in jumps 6->11 -> no change, no error. Then rst=0 in ERROR with clr_err=1 -> next edge shows all outputs 0 and state IDLE.
